// File: rtl/rx_serial_pkg.sv
// Shared serial definitions: receiver state codes and default line settings.
// Used by both the serial receiver and the serial transmitter.
package rx_serial_pkg;

  localparam int CLKS_PER_BIT_DEF = 434;
  localparam int DATA_BITS_DEF    = 7;

  typedef enum logic [3:0] {
    INICIAL    = 4'b0000,
    PREPARACAO = 4'b0001,
    ESPERA     = 4'b0011,
    RECEPCAO   = 4'b0111,
    ARMAZENA   = 4'b1011,
    FINAL_RX   = 4'b1111
  } rx_state_t;

endpackage

// File: rtl/rx_serial_uc.sv
// Receiver control FSM with registered Moore outputs.
// Ports: clock, reset, line, tick, primeiro, fim in; zera, conta,
//        desloca, registra, pronto, db_estado out.
module rx_serial_uc
  import rx_serial_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       line,
  input  logic       tick,
  input  logic       primeiro,
  input  logic       fim,
  output logic       zera,
  output logic       conta,
  output logic       desloca,
  output logic       registra,
  output logic       pronto,
  output logic [3:0] db_estado
);

  rx_state_t state;
  rx_state_t nxt;

  always_comb begin
    nxt = INICIAL;
    case (state)
      INICIAL:    nxt = line ? INICIAL : PREPARACAO;
      PREPARACAO: nxt = ESPERA;
      ESPERA:     nxt = tick ? RECEPCAO : ESPERA;
      RECEPCAO: begin
        // a high first sample means the start edge was a glitch
        if (primeiro && line) nxt = INICIAL;
        else if (fim)         nxt = ARMAZENA;
        else                  nxt = ESPERA;
      end
      ARMAZENA:   nxt = FINAL_RX;
      FINAL_RX:   nxt = INICIAL;
      default:    nxt = INICIAL;
    endcase
  end

  // outputs are decoded from the next state so they line up with state
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= INICIAL;
      zera      <= 1'b0;
      conta     <= 1'b0;
      desloca   <= 1'b0;
      registra  <= 1'b0;
      pronto    <= 1'b0;
      db_estado <= 4'b0000;
    end else begin
      state     <= nxt;
      zera      <= (nxt == PREPARACAO);
      conta     <= (nxt == ESPERA) || (nxt == RECEPCAO);
      desloca   <= (nxt == RECEPCAO);
      registra  <= (nxt == ARMAZENA);
      pronto    <= (nxt == FINAL_RX);
      db_estado <= nxt;
    end
  end

endmodule

// File: rtl/rx_serial.sv
// Serial receiver: start, DATA_BITS data LSB first, parity, stop.
// Ports: clock, reset, dado_serial in; dados_ascii, paridade_ok,
//        erro_stop, pronto, db_estado out.
module rx_serial
  import rx_serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int DATA_BITS    = DATA_BITS_DEF,
  parameter int PARITY_ODD   = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       dado_serial,
  output logic [7:0] dados_ascii,
  output logic       paridade_ok,
  output logic       erro_stop,
  output logic       pronto,
  output logic [3:0] db_estado
);

  localparam int NBITS = DATA_BITS + 3;
  localparam int CW    = $clog2(CLKS_PER_BIT);
  localparam int BW    = $clog2(NBITS + 1);
  localparam int SW    = NBITS - 1;

  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST    = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] FIM_CNT = BW'(NBITS - 1);

  logic          sync1;
  logic          line;
  logic [CW-1:0] cnt;
  logic [BW-1:0] bit_cnt;
  logic [SW-1:0] sr;
  logic          tick;
  logic          zera;
  logic          conta;
  logic          desloca;
  logic          registra;
  logic          par_x;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b1;
      line  <= 1'b1;
    end else begin
      sync1 <= dado_serial;
      line  <= sync1;
    end
  end

  // free-running mod CLKS_PER_BIT; first tick lands mid start bit
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (zera) begin
      cnt <= '0;
    end else if (conta) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  assign tick = (cnt == HALF_M1);

  // the start bit falls off the low end, so sr ends as {stop,par,data}
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bit_cnt <= '0;
      sr      <= '0;
    end else if (zera) begin
      bit_cnt <= '0;
      sr      <= '0;
    end else if (desloca) begin
      bit_cnt <= bit_cnt + 1'b1;
      sr      <= {line, sr[SW-1:1]};
    end
  end

  assign par_x = ^sr[DATA_BITS:0];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dados_ascii <= 8'h00;
      paridade_ok <= 1'b0;
      erro_stop   <= 1'b0;
    end else if (registra) begin
      dados_ascii <= 8'(sr[DATA_BITS-1:0]);
      paridade_ok <= (PARITY_ODD != 0) ? par_x : ~par_x;
      erro_stop   <= ~sr[SW-1];
    end
  end

  rx_serial_uc u_uc (
    .clock     (clock),
    .reset     (reset),
    .line      (line),
    .tick      (tick),
    .primeiro  (bit_cnt == '0),
    .fim       (bit_cnt == FIM_CNT),
    .zera      (zera),
    .conta     (conta),
    .desloca   (desloca),
    .registra  (registra),
    .pronto    (pronto),
    .db_estado (db_estado)
  );

endmodule

// File: doc/rx_serial.md
RX_SERIAL -- requirements
Module: rx_serial

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, clock cycles per bit (50 MHz / 115200); SHALL be an even value of at least 8.
REQ-002 Parameter DATA_BITS, default 7, data bits per frame, sent LSB first.
REQ-003 Parameter PARITY_ODD, default 1; value 1 selects odd parity, value 0 selects even parity.
REQ-004 Port clock  in  1  system clock; all state SHALL change on the rising edge.
REQ-005 Port reset  in  1  asynchronous, active-high reset.
REQ-006 Port dado_serial  in  1  serial line, idle high.
REQ-007 Port dados_ascii  out  8  last received data, zero-extended above DATA_BITS.
REQ-008 Port paridade_ok  out  1  1 when the parity of the last frame was correct.
REQ-009 Port erro_stop  out  1  1 when the stop bit of the last frame was sampled as 0.
REQ-010 Port pronto  out  1  single-cycle pulse marking a completed frame.
REQ-011 Port db_estado  out  4  current state code, for debug.

Function
REQ-012 Frame format SHALL be: start (0), DATA_BITS data bits LSB first, one parity bit, one stop bit (1). Total NBITS = DATA_BITS+3.
REQ-013 dado_serial SHALL pass through a 2-flop synchronizer; all logic SHALL use the synchronized value.
REQ-014 Baud counter:
  - zeroed in PREPARACAO;
  - raises tick for one cycle at count CLKS_PER_BIT/2-1, then every CLKS_PER_BIT cycles after that, so each bit is sampled mid-bit.
REQ-015 State codes and transitions:
  - INICIAL (0000): line=0 -> PREPARACAO, else stay.
  - PREPARACAO (0001): zero the counters and the shift register -> ESPERA.
  - ESPERA (0011): tick -> RECEPCAO, else stay.
  - RECEPCAO (0111): shift in the sample and increment the bit count.
    - first sample (start) = 1 -> INICIAL (false start);
    - bit count reaches NBITS -> ARMAZENA;
    - otherwise -> ESPERA.
  - ARMAZENA (1011): latch dados_ascii, paridade_ok and erro_stop -> FINAL_RX.
  - FINAL_RX (1111): pronto=1 -> INICIAL.
  - Any other code -> INICIAL.
REQ-016 pronto SHALL be high only in FINAL_RX, which is 3 cycles after the stop-bit tick cycle.
REQ-017 Parity check: paridade_ok SHALL be 1 when the XOR of the data and parity bits is 1 (odd mode) or 0 (even mode).
REQ-018 dados_ascii, paridade_ok and erro_stop SHALL change only in ARMAZENA and hold their values until the next ARMAZENA.
REQ-019 A frame with a parity or stop error SHALL still latch its data and pulse pronto.
REQ-020 A false start SHALL NOT change any registered output or pulse pronto.
REQ-021 The block SHALL accept a new start edge in INICIAL on the cycle right after FINAL_RX, so back-to-back frames are received.
REQ-022 Line activity outside INICIAL SHALL NOT affect the state machine; only the tick samples the line.

Reset
REQ-023 reset SHALL immediately force:
  - state to INICIAL;
  - counters, shift register and synchronizer flops (set to 1, idle) to their reset values;
  - dados_ascii=0, paridade_ok=0, erro_stop=0, pronto=0, db_estado=0000.
REQ-024 A reset in the middle of a frame SHALL abandon the frame; reception SHALL restart at the next falling edge after reset is released.

Structure
REQ-025 The state codes and the default CLKS_PER_BIT/DATA_BITS values SHALL live in a shared serial package, also used by the transmitter.
REQ-026 The control FSM SHALL be the sub-module rx_serial_uc (Moore outputs: zera, conta, desloca, registra, pronto, db_estado).
REQ-027 The datapath (synchronizer, baud counter, bit counter, shift register, output registers) SHALL be in rx_serial.

Verification (CLKS_PER_BIT=16, 7O1)
REQ-028 Send 'A' with frame 0,1000001,1,1 -> one pronto pulse; dados_ascii=8'h41, paridade_ok=1, erro_stop=0.
REQ-029 Send 0x41 with parity bit 0 -> pronto pulse; dados_ascii=8'h41, paridade_ok=0.
REQ-030 Send 0x55 with stop bit 0 -> pronto pulse; erro_stop=1, dados_ascii=8'h55.
REQ-031 Drive the line low for 4 cycles, then high -> db_estado returns to 0000; no pronto; outputs unchanged.
REQ-032 Assert reset during data bit 3 -> db_estado=0000 and outputs=0 at once; a following frame 0x2A is received correctly.
REQ-033 Send 0x30 and 0x31 back-to-back with no idle gap -> two pronto pulses, with values 8'h30 then 8'h31.
